// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - shared 7-segment codes and pattern decode for driver and scan decoder
package seven_seg_pkg;

    typedef logic [6:0] seg_t;

    // Segment order {a,b,c,d,e,f,g}, active-low, a in the MSB
    localparam seg_t SEG_0     = 7'b0000001;
    localparam seg_t SEG_1     = 7'b1001111;
    localparam seg_t SEG_2     = 7'b0010010;
    localparam seg_t SEG_3     = 7'b0000110;
    localparam seg_t SEG_4     = 7'b1001100;
    localparam seg_t SEG_5     = 7'b0100100;
    localparam seg_t SEG_6     = 7'b0100000;
    localparam seg_t SEG_7     = 7'b0001111;
    localparam seg_t SEG_8     = 7'b0000000;
    localparam seg_t SEG_9     = 7'b0000100;
    localparam seg_t SEG_A     = 7'b0001000;
    localparam seg_t SEG_B     = 7'b1100000;
    localparam seg_t SEG_C     = 7'b0110001;
    localparam seg_t SEG_D     = 7'b1000010;
    localparam seg_t SEG_E     = 7'b0110000;
    localparam seg_t SEG_F     = 7'b0111000;
    localparam seg_t SEG_BLANK = 7'b1111111;

    // Returns {hit, nibble}; hit is 0 for any pattern outside the hex table
    function automatic logic [4:0] seg_decode(input seg_t seg);
        case (seg)
            SEG_0:   return {1'b1, 4'h0};
            SEG_1:   return {1'b1, 4'h1};
            SEG_2:   return {1'b1, 4'h2};
            SEG_3:   return {1'b1, 4'h3};
            SEG_4:   return {1'b1, 4'h4};
            SEG_5:   return {1'b1, 4'h5};
            SEG_6:   return {1'b1, 4'h6};
            SEG_7:   return {1'b1, 4'h7};
            SEG_8:   return {1'b1, 4'h8};
            SEG_9:   return {1'b1, 4'h9};
            SEG_A:   return {1'b1, 4'hA};
            SEG_B:   return {1'b1, 4'hB};
            SEG_C:   return {1'b1, 4'hC};
            SEG_D:   return {1'b1, 4'hD};
            SEG_E:   return {1'b1, 4'hE};
            SEG_F:   return {1'b1, 4'hF};
            default: return 5'b0_0000;
        endcase
    endfunction

endpackage

// File: rtl/seg7_pattern_decoder.sv
// rtl/seg7_pattern_decoder.sv - combinational segment pattern to {hit, blank, nibble}
module seg7_pattern_decoder
    import seven_seg_pkg::*;
(
    input  seg_t       seg,
    output logic       hit,
    output logic       blank,
    output logic [3:0] nibble
);

    logic [4:0] dec;

    always_comb begin
        dec = seg_decode(seg);
    end

    assign hit    = dec[4];
    assign nibble = dec[3:0];
    assign blank  = (seg == SEG_BLANK);

endmodule

// File: rtl/seg7_scan_decoder.sv
// rtl/seg7_scan_decoder.sv - rebuilds per-digit hex values from scanned anode/segment lines
module seg7_scan_decoder
    import seven_seg_pkg::*;
#(
    parameter int w_7_indic     = 8,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [w_7_indic-1:0]   an_i,
    input  logic [6:0]             seg_i,
    input  logic                   dp_i,
    output logic [4*w_7_indic-1:0] digits_o,
    output logic [w_7_indic-1:0]   dp_o,
    output logic [w_7_indic-1:0]   valid_o,
    output logic                   frame_o,
    output logic                   err_o,
    output logic [7:0]             err_cnt_o
);

    localparam int         SW       = w_7_indic + 8;
    localparam int         IDX_W    = (w_7_indic > 1) ? $clog2(w_7_indic) : 1;
    localparam logic [7:0] CNT_MAX  = 8'(STABLE_CYCLES);
    localparam logic [7:0] CNT_FIRE = 8'(STABLE_CYCLES - 2);

    logic [SW-1:0]          samp_q;
    logic [SW-1:0]          prev_q;
    logic [7:0]             cnt_q;
    logic [7:0]             cnt_d;
    logic                   same;
    logic                   capture;

    logic [w_7_indic-1:0]   act;
    logic [w_7_indic-1:0]   act_m1;
    logic                   act_none;
    logic                   act_multi;
    logic [IDX_W-1:0]       idx;
    logic [IDX_W+1:0]       nib_lsb;
    seg_t                   cap_seg;
    logic                   cap_dp;

    logic                   dec_hit;
    logic                   dec_blank;
    logic [3:0]             dec_nibble;

    logic [4*w_7_indic-1:0] digits_d;
    logic [w_7_indic-1:0]   dp_d;
    logic [w_7_indic-1:0]   valid_d;
    logic [w_7_indic-1:0]   seen_q;
    logic [w_7_indic-1:0]   seen_d;
    logic                   frame_d;
    logic                   err_d;
    logic [7:0]             err_cnt_d;

    assign same    = (samp_q == prev_q);
    assign capture = same && (cnt_q == CNT_FIRE);

    always_comb begin
        cnt_d = cnt_q;
        if (!same) begin
            cnt_d = 8'd0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Anodes are active-low; work on the active-high view of the held sample
    assign act       = ~samp_q[SW-1:8];
    assign act_m1    = act - w_7_indic'(1);
    assign act_none  = (act == '0);
    assign act_multi = |(act & act_m1);
    assign cap_seg   = samp_q[7:1];
    assign cap_dp    = samp_q[0];

    always_comb begin
        idx = '0;
        for (int i = 0; i < w_7_indic; i++) begin
            if (act[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

    assign nib_lsb = {idx, 2'b00};

    seg7_pattern_decoder u_pattern_decoder (
        .seg    (cap_seg),
        .hit    (dec_hit),
        .blank  (dec_blank),
        .nibble (dec_nibble)
    );

    always_comb begin
        digits_d  = digits_o;
        dp_d      = dp_o;
        valid_d   = valid_o;
        seen_d    = seen_q;
        frame_d   = 1'b0;
        err_d     = 1'b0;
        err_cnt_d = err_cnt_o;
        if (capture && !act_none) begin
            if (act_multi || (!dec_hit && !dec_blank)) begin
                err_d = 1'b1;
            end else begin
                if (dec_hit) begin
                    digits_d[nib_lsb +: 4] = dec_nibble;
                    valid_d[idx]           = 1'b1;
                end else begin
                    valid_d[idx] = 1'b0;
                end
                dp_d[idx]   = ~cap_dp;
                seen_d[idx] = 1'b1;
                // Frame closes on the edge that writes the last missing digit
                if (&seen_d) begin
                    frame_d = 1'b1;
                    seen_d  = '0;
                end
            end
        end
        if (err_d && (err_cnt_o != 8'hFF)) begin
            err_cnt_d = err_cnt_o + 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            samp_q    <= '0;
            prev_q    <= '0;
            cnt_q     <= '0;
            digits_o  <= '0;
            dp_o      <= '0;
            valid_o   <= '0;
            seen_q    <= '0;
            frame_o   <= 1'b0;
            err_o     <= 1'b0;
            err_cnt_o <= '0;
        end else begin
            samp_q    <= {an_i, seg_i, dp_i};
            prev_q    <= samp_q;
            cnt_q     <= cnt_d;
            digits_o  <= digits_d;
            dp_o      <= dp_d;
            valid_o   <= valid_d;
            seen_q    <= seen_d;
            frame_o   <= frame_d;
            err_o     <= err_d;
            err_cnt_o <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb/tb_seg7_scan_decoder.sv - scoreboard bench for seg7_scan_decoder
module tb_seg7_scan_decoder;

    typedef struct {
        logic [31:0] d;
        logic [7:0]  v;
        logic [7:0]  dp;
        logic        fr;
        logic        er;
        logic [7:0]  ec;
        int          cyc;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [7:0]  an_i  = 8'hFF;
    logic [6:0]  seg_i = 7'h7F;
    logic        dp_i  = 1'b1;
    logic [31:0] digits_o;
    logic [7:0]  dp_o;
    logic [7:0]  valid_o;
    logic        frame_o;
    logic        err_o;
    logic [7:0]  err_cnt_o;

    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    bit          mon_en = 1'b0;
    exp_t        exp_q[$];
    exp_t        mon_e;

    logic [31:0] p_d;
    logic [7:0]  p_v, p_dp, p_ec;

    logic [31:0] m_d;
    logic [7:0]  m_v, m_dp, m_ec, m_seen;
    logic [6:0]  hex_tab [16];

    seg7_scan_decoder #(
        .w_7_indic     (8),
        .STABLE_CYCLES (4)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .an_i      (an_i),
        .seg_i     (seg_i),
        .dp_i      (dp_i),
        .digits_o  (digits_o),
        .dp_o      (dp_o),
        .valid_o   (valid_o),
        .frame_o   (frame_o),
        .err_o     (err_o),
        .err_cnt_o (err_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Any pulse or output change is a DUT event and must match the queue head
    always @(negedge clk_i) begin
        if (mon_en && (frame_o || err_o || digits_o !== p_d || valid_o !== p_v ||
                       dp_o !== p_dp || err_cnt_o !== p_ec)) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_event cyc=%0d digits=%h valid=%h dp=%h frame=%b err=%b cnt=%0d",
                         cyc, digits_o, valid_o, dp_o, frame_o, err_o, err_cnt_o);
            end else begin
                mon_e = exp_q.pop_front();
                n_checks++;
                if ({digits_o, valid_o, dp_o, frame_o, err_o, err_cnt_o} !==
                    {mon_e.d, mon_e.v, mon_e.dp, mon_e.fr, mon_e.er, mon_e.ec}) begin
                    $display("FAIL event_state got d=%h v=%h dp=%h fr=%b er=%b cnt=%0d want d=%h v=%h dp=%h fr=%b er=%b cnt=%0d",
                             digits_o, valid_o, dp_o, frame_o, err_o, err_cnt_o,
                             mon_e.d, mon_e.v, mon_e.dp, mon_e.fr, mon_e.er, mon_e.ec);
                end else begin
                    n_pass++;
                end
                n_checks++;
                if (cyc !== mon_e.cyc) begin
                    $display("FAIL event_cycle got %0d want %0d", cyc, mon_e.cyc);
                end else begin
                    n_pass++;
                end
            end
        end
        p_d  = digits_o;
        p_v  = valid_o;
        p_dp = dp_o;
        p_ec = err_cnt_o;
    end

    task automatic model_clear();
        m_d = '0; m_v = '0; m_dp = '0; m_ec = '0; m_seen = '0;
    endtask

    // Drive one stable pattern for 'hold' edges and predict what a capture should do
    task automatic drive(input logic [7:0] an, input logic [6:0] seg, input logic dp, input int hold);
        exp_t e;
        logic [7:0] a;
        int nb, k, val;
        bit err;
        an_i = an; seg_i = seg; dp_i = dp;
        a = ~an; nb = 0; k = 0; err = 0;
        for (int i = 0; i < 8; i++) if (a[i]) begin nb++; k = i; end
        if (hold >= 4 && nb != 0) begin
            e.fr = 1'b0;
            if (nb > 1) begin
                err = 1;
            end else begin
                val = -1;
                for (int h = 0; h < 16; h++) if (hex_tab[h] == seg) val = h;
                if (val >= 0) begin
                    m_d[4*k +: 4] = 4'(val); m_v[k] = 1'b1; m_dp[k] = ~dp; m_seen[k] = 1'b1;
                end else if (seg == 7'b1111111) begin
                    m_v[k] = 1'b0; m_dp[k] = ~dp; m_seen[k] = 1'b1;
                end else begin
                    err = 1;
                end
                if (m_seen == 8'hFF) begin e.fr = 1'b1; m_seen = '0; end
            end
            if (err && m_ec != 8'hFF) m_ec = m_ec + 8'd1;
            e.d = m_d; e.v = m_v; e.dp = m_dp; e.er = err; e.ec = m_ec;
            e.cyc = cyc + 5;
            exp_q.push_back(e);
        end
        repeat (hold) @(posedge clk_i);
        #1;
    endtask

    task automatic blank_gap(input int n);
        drive(8'hFF, 7'h7F, 1'b1, n);
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        an_i = 8'($urandom); seg_i = 7'($urandom); dp_i = 1'($urandom);
        repeat (3) @(posedge clk_i);
        #1;
        n_checks++;
        if ({digits_o, dp_o, valid_o} !== 48'h0) begin
            $display("FAIL reset_data got d=%h dp=%h v=%h want 0", digits_o, dp_o, valid_o);
        end else n_pass++;
        n_checks++;
        if ({frame_o, err_o, err_cnt_o} !== 10'h0) begin
            $display("FAIL reset_pulse got fr=%b er=%b cnt=%0d want 0", frame_o, err_o, err_cnt_o);
        end else n_pass++;
        rst_i = 1'b0; an_i = 8'hFF; seg_i = 7'h7F; dp_i = 1'b1;
        model_clear();
        @(negedge clk_i); #1 mon_en = 1'b1;
        @(posedge clk_i); #1;
    endtask

    task automatic test_idle();
        repeat (20) @(posedge clk_i);
        #1;
        n_checks++;
        if ({digits_o, valid_o, err_cnt_o} !== 48'h0) begin
            $display("FAIL idle_outputs got d=%h v=%h cnt=%0d want 0", digits_o, valid_o, err_cnt_o);
        end else n_pass++;
    endtask

    task automatic test_single_digit();
        drive(8'b11111011, 7'b0000110, 1'b0, 6);
        blank_gap(2);
        n_checks++;
        if ({digits_o[11:8], valid_o[2], dp_o[2]} !== 6'b0011_1_1) begin
            $display("FAIL single_digit got nib=%h v=%b dp=%b want 3 1 1", digits_o[11:8], valid_o[2], dp_o[2]);
        end else n_pass++;
    endtask

    task automatic test_full_frame();
        for (int k = 0; k < 8; k++) begin
            drive(8'hFF ^ (8'd1 << k), hex_tab[k], 1'b1, 6);
            blank_gap(2);
        end
        n_checks++;
        if ({digits_o, valid_o} !== {32'h76543210, 8'hFF}) begin
            $display("FAIL full_frame got d=%h v=%h want 76543210 ff", digits_o, valid_o);
        end else n_pass++;
    endtask

    task automatic test_glitch();
        drive(8'hFD, hex_tab[10], 1'b0, 3);
        blank_gap(8);
        n_checks++;
        if (digits_o !== m_d) begin
            $display("FAIL glitch got d=%h want %h", digits_o, m_d);
        end else n_pass++;
    endtask

    task automatic test_errors();
        drive(8'b11111100, hex_tab[0], 1'b1, 6);
        blank_gap(2);
        drive(8'hFE, 7'b1010101, 1'b1, 6);
        blank_gap(2);
        n_checks++;
        if ({err_cnt_o, digits_o[3:0]} !== {8'd2, 4'h0}) begin
            $display("FAIL errors got cnt=%0d d0=%h want 2 0", err_cnt_o, digits_o[3:0]);
        end else n_pass++;
    endtask

    task automatic test_blank_capture();
        drive(8'hEF, 7'h7F, 1'b0, 6);
        blank_gap(2);
        n_checks++;
        if ({valid_o[4], dp_o[4], digits_o[19:16]} !== {1'b0, 1'b1, 4'h4}) begin
            $display("FAIL blank_capture got v=%b dp=%b nib=%h want 0 1 4", valid_o[4], dp_o[4], digits_o[19:16]);
        end else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        for (int k = 0; k < 4; k++) begin
            drive(8'hFF ^ (8'd1 << k), hex_tab[8 + k], 1'b1, 6);
            blank_gap(2);
        end
        mon_en = 1'b0;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        model_clear();
        n_checks++;
        if ({digits_o, valid_o, err_cnt_o} !== 48'h0) begin
            $display("FAIL mid_reset got d=%h v=%h cnt=%0d want 0", digits_o, valid_o, err_cnt_o);
        end else n_pass++;
        @(negedge clk_i); #1 mon_en = 1'b1;
        @(posedge clk_i); #1;
        for (int k = 4; k < 8; k++) begin
            drive(8'hFF ^ (8'd1 << k), hex_tab[8 + k], 1'b0, 6);
            blank_gap(2);
        end
        n_checks++;
        if ({valid_o, digits_o} !== {8'hF0, 32'hFEDC0000}) begin
            $display("FAIL reset_mid_frame got v=%h d=%h want f0 fedc0000", valid_o, digits_o);
        end else n_pass++;
    endtask

    task automatic test_drain();
        repeat (10) @(posedge clk_i);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            $display("FAIL missing_events got %0d pending want 0", exp_q.size());
        end else n_pass++;
    endtask

    initial begin
        hex_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
        model_clear();
        test_reset();
        test_idle();
        test_single_digit();
        test_full_frame();
        test_glitch();
        test_errors();
        test_blank_capture();
        test_reset_mid_frame();
        test_drain();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
